// File: rtl/step_pulse_generator.sv
// ---------------------------------------------------------------------------
// step_pulse_generator
// Single-axis STEP/DIR pulse generator for a stepper driver. Converts a
// direction and speed request into driver-compliant STEP pulses with a
// guaranteed pulse width, DIR setup time and minimum period. It honours the
// limit switches and keeps a signed step-position count.
//
// Ports
//   clock        in   system clock, rising edge
//   reset        in   synchronous active-high reset
//   enable       in   stepping permitted
//   speed        in   cycles per step (0 = stop, below MIN_PERIOD clamped)
//   dir          in   requested direction (1 = positive)
//   lim_pos      in   positive-end limit switch, active-high
//   lim_neg      in   negative-end limit switch, active-high
//   zero_pos     in   one-cycle pulse: position <- 0
//   clear_fault  in   one-cycle pulse: clear the sticky fault
//   step         out  STEP to driver (registered)
//   dir_out      out  DIR to driver (registered)
//   position     out  signed step count (registered)
//   busy         out  high whenever the FSM is not idle
//   fault        out  sticky: step requested toward an asserted limit
//
// state       | meaning
// ------------+----------------------------------------------------------
// S_IDLE      | no motion, evaluating the request every cycle
// S_DIR_SETUP | DIR changed, holding it stable before the next STEP edge
// S_PULSE_HIGH| STEP high for PULSE_WIDTH cycles
// S_PULSE_LOW | STEP low for the rest of the latched period
// ---------------------------------------------------------------------------
module step_pulse_generator #(
    parameter int unsigned PULSE_WIDTH = 50,
    parameter int unsigned DIR_SETUP   = 20,
    parameter int unsigned MIN_PERIOD  = 100,
    parameter int unsigned POS_WIDTH   = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [31:0]          speed,
    input  logic                 dir,
    input  logic                 lim_pos,
    input  logic                 lim_neg,
    input  logic                 zero_pos,
    input  logic                 clear_fault,
    output logic                 step,
    output logic                 dir_out,
    output logic [POS_WIDTH-1:0] position,
    output logic                 busy,
    output logic                 fault
);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_DIR_SETUP  = 2'd1,
        S_PULSE_HIGH = 2'd2,
        S_PULSE_LOW  = 2'd3
    } state_t;

    // Down-counters are loaded with (duration - 1) and finish at zero.
    localparam logic [31:0] PW_M1 = 32'(PULSE_WIDTH - 1);
    localparam logic [31:0] PW_P1 = 32'(PULSE_WIDTH + 1);
    localparam logic [31:0] DS_M1 = 32'(DIR_SETUP - 1);
    localparam logic [31:0] MIN_P = 32'(MIN_PERIOD);

    state_t               state_q, state_d;
    logic [31:0]          cnt_q, cnt_d;
    logic [31:0]          period_q, period_d;
    logic                 step_q, step_d;
    logic                 dir_q, dir_d;
    logic                 fault_q, fault_d;
    logic [POS_WIDTH-1:0] pos_q, pos_d;

    logic        request;
    logic        blocked_req;
    logic        blocked_cur;
    logic [31:0] period_clamped;
    logic        evaluate;
    logic        go_high;
    logic        fault_set;

    always_comb begin
        request        = enable && (speed != 32'd0);
        blocked_req    = dir ? lim_pos : lim_neg;
        // After a setup phase the committed direction is what gets checked.
        blocked_cur    = dir_q ? lim_pos : lim_neg;
        period_clamped = (speed < MIN_P) ? MIN_P : speed;

        state_d   = state_q;
        cnt_d     = cnt_q;
        period_d  = period_q;
        step_d    = step_q;
        dir_d     = dir_q;
        evaluate  = 1'b0;
        go_high   = 1'b0;
        fault_set = 1'b0;

        case (state_q)
            S_IDLE: evaluate = 1'b1;
            S_DIR_SETUP: begin
                if (cnt_q == 32'd0) begin
                    if (blocked_cur) begin
                        state_d   = S_IDLE;
                        fault_set = 1'b1;
                    end else begin
                        go_high = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            S_PULSE_HIGH: begin
                if (cnt_q == 32'd0) begin
                    state_d = S_PULSE_LOW;
                    step_d  = 1'b0;
                    cnt_d   = period_q - PW_P1;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            S_PULSE_LOW: begin
                // End of period is evaluated exactly like idle so that
                // continuous motion has no gap between periods.
                if (cnt_q == 32'd0) begin
                    evaluate = 1'b1;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (evaluate) begin
            if (!request) begin
                state_d = S_IDLE;
            end else if (blocked_req) begin
                state_d   = S_IDLE;
                fault_set = 1'b1;
            end else if (dir == dir_q) begin
                go_high = 1'b1;
            end else begin
                state_d = S_DIR_SETUP;
                dir_d   = dir;
                cnt_d   = DS_M1;
            end
        end

        if (go_high) begin
            state_d  = S_PULSE_HIGH;
            step_d   = 1'b1;
            period_d = period_clamped;
            cnt_d    = PW_M1;
        end

        pos_d = pos_q;
        if (go_high) begin
            pos_d = dir_q ? (pos_q + POS_WIDTH'(1)) : (pos_q - POS_WIDTH'(1));
        end
        if (zero_pos) begin
            pos_d = '0;
        end

        // A set in the same cycle as a clear leaves the fault asserted.
        fault_d = fault_set || (fault_q && !clear_fault);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            period_q <= '0;
            step_q   <= 1'b0;
            dir_q    <= 1'b0;
            fault_q  <= 1'b0;
            pos_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            step_q   <= step_d;
            dir_q    <= dir_d;
            fault_q  <= fault_d;
            pos_q    <= pos_d;
        end
    end

    assign step     = step_q;
    assign dir_out  = dir_q;
    assign position = pos_q;
    assign busy     = (state_q != S_IDLE);
    assign fault    = fault_q;

endmodule

// File: tb/tb_step_pulse_generator.sv
// ---------------------------------------------------------------------------
// tb_step_pulse_generator
// Directed scenarios followed by randomized stimulus. A timeline reference
// model (last rising-edge time, latched period, setup end time) predicts
// step, dir_out, position, busy and fault after every clock edge.
// ---------------------------------------------------------------------------
module tb_step_pulse_generator;

    localparam int PW  = 4;
    localparam int DS  = 3;
    localparam int MIN = 10;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic [31:0] speed = 32'd0;
    logic        dir = 1'b0;
    logic        lim_pos = 1'b0;
    logic        lim_neg = 1'b0;
    logic        zero_pos = 1'b0;
    logic        clear_fault = 1'b0;
    logic        step;
    logic        dir_out;
    logic [31:0] position;
    logic        busy;
    logic        fault;

    step_pulse_generator #(
        .PULSE_WIDTH(PW),
        .DIR_SETUP  (DS),
        .MIN_PERIOD (MIN),
        .POS_WIDTH  (32)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .speed      (speed),
        .dir        (dir),
        .lim_pos    (lim_pos),
        .lim_neg    (lim_neg),
        .zero_pos   (zero_pos),
        .clear_fault(clear_fault),
        .step       (step),
        .dir_out    (dir_out),
        .position   (position),
        .busy       (busy),
        .fault      (fault)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: a timeline of events rather than a state machine.
    longint      t = 0;
    bit          m_active = 0;
    bit          m_setup = 0;
    longint      m_setup_end = 0;
    longint      m_rise = -1000;
    longint      m_per = 0;
    bit          m_dir = 0;
    logic [31:0] m_pos = 32'd0;
    bit          m_fault = 0;

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs != exp) begin
            errors++;
            if (errors <= 30)
                $display("FAIL %s at edge %0d: got %0d expected %0d", tag, t, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit evalq;
        bit start;
        bit set_f;
        t++;
        if (reset) begin
            m_active = 0; m_setup = 0; m_rise = -1000; m_per = 0;
            m_dir = 0; m_pos = 32'd0; m_fault = 0;
            return;
        end
        evalq = 0; start = 0; set_f = 0;
        if (!m_active) evalq = 1;
        else if (m_setup) begin
            if (t == m_setup_end) begin
                m_setup = 0;
                if (m_dir ? lim_pos : lim_neg) begin m_active = 0; set_f = 1; end
                else start = 1;
            end
        end else if (t == m_rise + m_per) evalq = 1;

        if (evalq) begin
            if (!(enable && speed != 0)) m_active = 0;
            else if (dir ? lim_pos : lim_neg) begin m_active = 0; set_f = 1; end
            else if (dir == m_dir) start = 1;
            else begin
                m_dir = dir; m_active = 1; m_setup = 1; m_setup_end = t + DS;
            end
        end
        if (start) begin
            m_active = 1; m_setup = 0; m_rise = t;
            m_per = (speed < MIN) ? MIN : longint'(speed);
            m_pos = m_dir ? m_pos + 32'd1 : m_pos - 32'd1;
        end
        if (zero_pos) m_pos = 32'd0;
        m_fault = set_f || (m_fault && !clear_fault);
    endtask

    task automatic tick();
        bit exp_step;
        @(posedge clock);
        model_edge();
        #1;
        exp_step = m_active && !m_setup && (t - m_rise) < PW;
        check("step", step, exp_step);
        check("dir_out", dir_out, m_dir);
        check("position", position, m_pos);
        check("busy", busy, m_active);
        check("fault", fault, m_fault);
        reset = 0; zero_pos = 0; clear_fault = 0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Advance until the DUT shows the wanted step level; expiry is a failure.
    task automatic wait_step(input bit lvl, input int budget);
        int k = 0;
        while (step !== lvl && k < budget) begin tick(); k++; end
        if (step !== lvl) check("wait_step_timeout", step, lvl);
    endtask

    function automatic logic [31:0] pick_speed();
        case ($urandom_range(0, 3))
            0:       return 32'd0;
            1:       return 32'($urandom_range(1, 9));
            2:       return 32'($urandom_range(10, 25));
            default: return 32'($urandom_range(26, 40));
        endcase
    endfunction

    initial begin
        // Reset state, then steady negative motion at speed 20.
        reset = 1; tick();
        reset = 1; tick();
        enable = 1; speed = 32'd20; dir = 0;
        run(100);
        enable = 0; run(25);

        // Reversal from reset dir_out with clamped period.
        reset = 1; tick();
        enable = 1; speed = 32'd5; dir = 1;
        run(45);
        enable = 0; run(15);

        // Enable dropped two cycles into a pulse.
        speed = 32'd20; dir = 1; enable = 1;
        wait_step(1, 40);
        run(2);
        enable = 0; run(30);

        // Limit switch blocking, then stepping away, then fault clear.
        lim_pos = 1; dir = 1; enable = 1;
        run(10);
        dir = 0; run(45);
        clear_fault = 1; tick();
        enable = 0; lim_pos = 0; run(25);

        // Direction toggled mid-period.
        speed = 32'd12; dir = 0; enable = 1;
        run(30);
        dir = 1; run(40);
        enable = 0; run(20);

        // zero_pos coincident with the rising edge that would reach 7.
        reset = 1; tick();
        dir = 1; speed = 32'd10; enable = 1;
        begin
            int k = 0;
            while (position !== 32'd6 && k < 100) begin tick(); k++; end
            if (position !== 32'd6) check("wait_pos6_timeout", position, 6);
        end
        run(9);
        zero_pos = 1; tick();
        // Reset in the middle of a pulse.
        wait_step(1, 30);
        run(1);
        reset = 1; tick();
        enable = 0; run(5);

        // Randomized phase.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0) enable = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 59) == 0) speed = pick_speed();
            if ($urandom_range(0, 49) == 0) dir = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 119) == 0) lim_pos = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 119) == 0) lim_neg = ($urandom_range(0, 2) == 0);
            zero_pos    = ($urandom_range(0, 149) == 0);
            clear_fault = ($urandom_range(0, 79) == 0);
            reset       = ($urandom_range(0, 999) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
